// File: rtl/serial_addsub_ctrl_pkg.sv
// rtl/serial_addsub_ctrl_pkg.sv - shared state encodings for the serial add/sub sequencer
package serial_addsub_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// rtl/serial_addsub_ctrl_if.sv - operand/result handshake bundle for the serial add/sub sequencer
interface serial_addsub_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, cout, ovf
  );

endinterface

// File: rtl/serial_addsub_ctrl_fulladder.sv
// rtl/serial_addsub_ctrl_fulladder.sv - 1-bit full adder cell
module serial_addsub_ctrl_fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - bit-serial adder/subtractor sequencer around one full adder cell
module serial_addsub_ctrl
  import serial_addsub_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_addsub_ctrl_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SR_W  = WIDTH - 1;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [SR_W-1:0]  sum_sr;
  logic             carry;
  logic [CNT_W-1:0] bitcnt;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             ovf_q;
  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;

  serial_addsub_ctrl_fulladder u_fa (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit = (bitcnt == CNT_W'(WIDTH - 1));

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_a     <= '0;
      op_b     <= '0;
      sum_sr   <= '0;
      carry    <= 1'b0;
      bitcnt   <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            op_a   <= bus.a;
            // subtraction is A + ~B + 1: invert B here, the +1 rides in on the carry
            op_b   <= bus.b ^ {WIDTH{bus.sub}};
            carry  <= bus.sub;
            bitcnt <= '0;
            state  <= ST_RUN;
          end
        end

        ST_RUN: begin
          // the low WIDTH-1 sum bits collect here; the MSB joins them when the result is latched
          sum_sr <= SR_W'({fa_sum, sum_sr} >> 1);
          carry  <= fa_cout;
          op_a   <= op_a >> 1;
          op_b   <= op_b >> 1;
          if (last_bit) begin
            result_q <= {fa_sum, sum_sr};
            cout_q   <= fa_cout;
            ovf_q    <= carry ^ fa_cout;
            state    <= ST_DONE;
          end else begin
            bitcnt <= bitcnt + 1'b1;
          end
        end

        ST_DONE: begin
          if (bus.out_ready) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb/tb_serial_addsub_ctrl.sv - scoreboard bench for the serial add/sub sequencer
module tb_serial_addsub_ctrl;

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       o;
    int         acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  serial_addsub_ctrl_if #(.WIDTH(8)) ifc ();

  serial_addsub_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                      input logic [7:0] er, input logic ec, input logic eo);
    int n;
    n = 0;
    @(negedge clk);
    while (!ifc.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.in_ready) begin
      check("send_timeout_in_ready", 32'(ifc.in_ready), 32'd1);
      return;
    end
    ifc.a        = av;
    ifc.b        = bv;
    ifc.sub      = sv;
    ifc.in_valid = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back('{er, ec, eo, cyc});
    ifc.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !ifc.in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // monitor: latency on valid rise, values on handshake
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (ifc.out_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_valid: got result 0x%0h with no pending op, expected none", ifc.result);
          end else begin
            check("latency", 32'(cyc - exp_q[0].acc), 32'd8);
          end
        end
        if (ifc.out_valid && ifc.out_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("result", 32'(ifc.result), 32'(e.r));
          check("cout", 32'(ifc.cout), 32'(e.c));
          check("ovf", 32'(ifc.ovf), 32'(e.o));
        end
        prev_valid = ifc.out_valid;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    ifc.in_valid  = 1'b0;
    ifc.a         = 8'h00;
    ifc.b         = 8'h00;
    ifc.sub       = 1'b0;
    ifc.out_ready = 1'b1;

    // reset with toggling inputs
    repeat (4) begin
      @(negedge clk);
      ifc.in_valid  = 1'($urandom);
      ifc.a         = 8'($urandom);
      ifc.b         = 8'($urandom);
      ifc.sub       = 1'($urandom);
      ifc.out_ready = 1'($urandom);
    end
    @(negedge clk);
    check("reset_out_valid", 32'(ifc.out_valid), 32'd0);
    check("reset_result", 32'(ifc.result), 32'd0);
    check("reset_cout", 32'(ifc.cout), 32'd0);
    check("reset_ovf", 32'(ifc.ovf), 32'd0);
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 32'(ifc.in_ready), 32'd1);

    // directed arithmetic
    send(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
    send(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    send(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    send(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    send(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    send(8'h33, 8'h00, 1'b1, 8'h33, 1'b1, 1'b0);
    drain();

    // backpressure in DONE with new operands waiting
    @(posedge clk);
    #1 ifc.out_ready = 1'b0;
    send(8'h55, 8'h22, 1'b0, 8'h77, 1'b0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!ifc.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("hold_reach_done", 32'(ifc.out_valid), 32'd1);
    ifc.a        = 8'h90;
    ifc.b        = 8'h20;
    ifc.sub      = 1'b1;
    ifc.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("hold_in_ready", 32'(ifc.in_ready), 32'd0);
      check("hold_out_valid", 32'(ifc.out_valid), 32'd1);
      check("hold_result", 32'(ifc.result), 32'h77);
    end
    @(posedge clk);
    #1 ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_to_idle", 32'(ifc.in_ready), 32'd1);
    check("release_valid_low", 32'(ifc.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("accept_edge_after_idle", 32'(ifc.in_ready), 32'd0);
    exp_q.push_back('{8'h70, 1'b1, 1'b1, cyc});
    ifc.in_valid = 1'b0;
    drain();

    // reset in the middle of RUN
    @(negedge clk);
    ifc.a        = 8'hAA;
    ifc.b        = 8'h11;
    ifc.sub      = 1'b0;
    ifc.in_valid = 1'b1;
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(ifc.out_valid), 32'd0);
    check("abort_result", 32'(ifc.result), 32'd0);
    check("abort_cout", 32'(ifc.cout), 32'd0);
    check("abort_ovf", 32'(ifc.ovf), 32'd0);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 32'(ifc.in_ready), 32'd1);
    repeat (12) @(negedge clk);
    check("abort_no_result", 32'(ifc.out_valid), 32'd0);
    send(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    drain();

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
